// File: rtl/mul_01bitx08_wallace_col_pkg.sv
// Shared constants for the Wallace-tree column slice.
//   NUM_W : number of equal-weight one-bit operands entering a column
//   CRY_W : number of lateral carries passed from one column to the next
package mul_01bitx08_wallace_col_pkg;

  localparam int unsigned NUM_W = 8;
  localparam int unsigned CRY_W = 6;

endpackage

// File: rtl/mul_01bitx08_wallace_col_if.sv
// Signal bundle for one Wallace-tree column, convenient for wrappers and
// benches that drive or chain columns.
//   en      : output-register load enable
//   num     : one-bit operands of the column
//   cry_in  : lateral carries from the lower column
//   cry_out : lateral carries to the higher column
//   res     : column sum bit (weight 1)
//   cry     : column carry bit (weight 2)
// master drives the operands, slave is the column itself.
interface mul_01bitx08_wallace_col_if;
  import mul_01bitx08_wallace_col_pkg::*;

  logic             en;
  logic [NUM_W-1:0] num;
  logic [CRY_W-1:0] cry_in;
  logic [CRY_W-1:0] cry_out;
  logic             res;
  logic             cry;

  modport master (output en, num, cry_in, input  cry_out, res, cry);
  modport slave  (input  en, num, cry_in, output cry_out, res, cry);

endinterface

// File: rtl/add_01bit_full.sv
// One-bit full adder.
//   i_a, i_b, i_cin : three equal-weight input bits
//   o_sum           : sum bit, weight 1
//   o_cry           : carry bit (majority), weight 2
module add_01bit_full (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cry
);

  assign o_sum = i_a ^ i_b ^ i_cin;
  assign o_cry = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);

endmodule

// File: rtl/mul_01bitx08_wallace_col.sv
// One column slice of a Wallace-tree partial-product compressor.
// Reduces 8 operand bits plus 6 lateral carry-ins to one sum bit and one
// carry bit; the 6 lateral carry-outs feed the next column combinationally.
//   i_clk       : clock, rising edge
//   i_rst_n     : synchronous active-low reset of the output register
//   i_en        : output-register load enable
//   i_num       : operand bits of this column (equal weight)
//   i_cry_06bit : lateral carries from the lower column
//   o_cry_06bit : lateral carries to the higher column (always combinational)
//   o_res       : column sum bit, weight 1
//   o_cry       : column carry bit, weight 2
// P_REG_OUT = 1 registers o_res/o_cry (1-cycle latency); 0 makes them
// combinational and leaves clock/reset/enable unused.
module mul_01bitx08_wallace_col
  import mul_01bitx08_wallace_col_pkg::*;
#(
  parameter bit P_REG_OUT = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic [NUM_W-1:0] i_num,
  input  logic [CRY_W-1:0] i_cry_06bit,
  output logic [CRY_W-1:0] o_cry_06bit,
  output logic             o_res,
  output logic             o_cry
);

  logic s0, s1, s2, s3, s4, s5;
  logic res_d, cry_d;

  // Level 1
  add_01bit_full u_fa0 (.i_a(i_num[7]), .i_b(i_num[6]), .i_cin(i_num[5]),
                        .o_sum(s0), .o_cry(o_cry_06bit[0]));
  add_01bit_full u_fa1 (.i_a(i_num[4]), .i_b(i_num[3]), .i_cin(i_num[2]),
                        .o_sum(s1), .o_cry(o_cry_06bit[1]));
  // Level 2
  add_01bit_full u_fa2 (.i_a(s0), .i_b(s1), .i_cin(i_num[1]),
                        .o_sum(s2), .o_cry(o_cry_06bit[2]));
  add_01bit_full u_fa3 (.i_a(i_num[0]), .i_b(i_cry_06bit[0]), .i_cin(i_cry_06bit[1]),
                        .o_sum(s3), .o_cry(o_cry_06bit[3]));
  // Level 3
  add_01bit_full u_fa4 (.i_a(s2), .i_b(s3), .i_cin(i_cry_06bit[2]),
                        .o_sum(s4), .o_cry(o_cry_06bit[4]));
  // Level 4
  add_01bit_full u_fa5 (.i_a(s4), .i_b(i_cry_06bit[3]), .i_cin(i_cry_06bit[4]),
                        .o_sum(s5), .o_cry(o_cry_06bit[5]));

  // Level 5: half adder
  assign res_d = s5 ^ i_cry_06bit[5];
  assign cry_d = s5 & i_cry_06bit[5];

  if (P_REG_OUT) begin : g_reg
    logic res_q, cry_q;

    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        res_q <= 1'b0;
        cry_q <= 1'b0;
      end else if (i_en) begin
        res_q <= res_d;
        cry_q <= cry_d;
      end
    end

    assign o_res = res_q;
    assign o_cry = cry_q;
  end else begin : g_comb
    assign o_res = res_d;
    assign o_cry = cry_d;
  end

endmodule

// File: tb/tb_mul_01bitx08_wallace_col.sv
module tb_mul_01bitx08_wallace_col;

  logic clk;
  logic rst_n;

  int unsigned n_checks;
  int unsigned n_errors;

  mul_01bitx08_wallace_col_if ifc_r ();
  mul_01bitx08_wallace_col_if ifc_c ();

  mul_01bitx08_wallace_col #(.P_REG_OUT(1'b1)) u_dut_reg (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_en        (ifc_r.en),
    .i_num       (ifc_r.num),
    .i_cry_06bit (ifc_r.cry_in),
    .o_cry_06bit (ifc_r.cry_out),
    .o_res       (ifc_r.res),
    .o_cry       (ifc_r.cry)
  );

  mul_01bitx08_wallace_col #(.P_REG_OUT(1'b0)) u_dut_comb (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_en        (ifc_c.en),
    .i_num       (ifc_c.num),
    .i_cry_06bit (ifc_c.cry_in),
    .o_cry_06bit (ifc_c.cry_out),
    .o_res       (ifc_c.res),
    .o_cry       (ifc_c.cry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: each adder cell is just "count the ones", the 2-bit count
  // being {carry, sum}.
  function automatic logic [1:0] add3(input logic a, input logic b, input logic c);
    int unsigned t;
    t = int'(a) + int'(b) + int'(c);
    return t[1:0];
  endfunction

  task automatic model(input  logic [7:0] n, input logic [5:0] ci,
                       output logic [5:0] co, output logic r, output logic c);
    logic [1:0] f0, f1, f2, f3, f4, f5;
    f0 = add3(n[7], n[6], n[5]);
    f1 = add3(n[4], n[3], n[2]);
    f2 = add3(f0[0], f1[0], n[1]);
    f3 = add3(n[0], ci[0], ci[1]);
    f4 = add3(f2[0], f3[0], ci[2]);
    f5 = add3(f4[0], ci[3], ci[4]);
    co = {f5[1], f4[1], f3[1], f2[1], f1[1], f0[1]};
    {c, r} = add3(f5[0], ci[5], 1'b0);
  endtask

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  logic exp_res_q, exp_cry_q, reg_known;

  task automatic step(input bit rst_v, input bit en_v, input logic [7:0] n, input logic [5:0] ci);
    logic [5:0] e_co;
    logic       e_r, e_c;
    int unsigned lhs, rhs;
    rst_n = rst_v;
    ifc_r.en = en_v;  ifc_r.num = n;  ifc_r.cry_in = ci;
    ifc_c.en = en_v;  ifc_c.num = n;  ifc_c.cry_in = ci;
    model(n, ci, e_co, e_r, e_c);
    #1;
    check("cout_reg",  {2'b00, ifc_r.cry_out}, {2'b00, e_co});
    check("cout_comb", {2'b00, ifc_c.cry_out}, {2'b00, e_co});
    check("res_comb",  {7'd0, ifc_c.res}, {7'd0, e_r});
    check("cry_comb",  {7'd0, ifc_c.cry}, {7'd0, e_c});
    lhs = $countones(n) + $countones(ci);
    rhs = int'(ifc_c.res) + 2 * (int'(ifc_c.cry) + $countones(ifc_c.cry_out));
    check("conserve", rhs[7:0], lhs[7:0]);
    @(posedge clk);
    if (!rst_v) begin
      exp_res_q = 1'b0; exp_cry_q = 1'b0; reg_known = 1'b1;
    end else if (en_v) begin
      exp_res_q = e_r;  exp_cry_q = e_c;
    end
    #1;
    if (reg_known) begin
      check("res_reg", {7'd0, ifc_r.res}, {7'd0, exp_res_q});
      check("cry_reg", {7'd0, ifc_r.cry}, {7'd0, exp_cry_q});
    end
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    reg_known = 1'b0;
    exp_res_q = 1'b0;
    exp_cry_q = 1'b0;

    // Reset, then directed vectors
    step(1'b0, 1'b1, 8'h00, 6'h00);
    check("rst_res", {7'd0, ifc_r.res}, 8'd0);
    check("rst_cry", {7'd0, ifc_r.cry}, 8'd0);
    step(1'b1, 1'b1, 8'b0000_0010, 6'h00);
    check("dir_res1", {7'd0, ifc_r.res}, 8'd1);
    check("dir_cout1", {2'b00, ifc_r.cry_out}, 8'b0000_0000);
    step(1'b1, 1'b1, 8'b0000_0011, 6'h00);
    check("dir_cout2", {2'b00, ifc_r.cry_out}, 8'b0001_0000);
    step(1'b1, 1'b1, 8'b0000_0110, 6'h00);
    check("dir_cout3", {2'b00, ifc_r.cry_out}, 8'b0000_0100);
    step(1'b1, 1'b1, 8'b1100_0000, 6'h00);
    check("dir_cout4", {2'b00, ifc_r.cry_out}, 8'b0000_0001);
    step(1'b1, 1'b1, 8'hFF, 6'h3F);
    check("dir_cout5", {2'b00, ifc_r.cry_out}, 8'b0011_1111);
    check("dir_res5", {7'd0, ifc_r.res}, 8'd0);
    check("dir_cry5", {7'd0, ifc_r.cry}, 8'd1);

    // Hold with enable low, then reset overriding enable
    step(1'b1, 1'b1, 8'b0000_0010, 6'h00);
    step(1'b1, 1'b0, 8'hFF, 6'h3F);
    check("hold_res", {7'd0, ifc_r.res}, 8'd1);
    step(1'b1, 1'b0, 8'b0000_0011, 6'h15);
    check("hold_res2", {7'd0, ifc_r.res}, 8'd1);
    step(1'b0, 1'b1, 8'b0000_0010, 6'h00);
    check("rst_en_res", {7'd0, ifc_r.res}, 8'd0);
    check("rst_en_cry", {7'd0, ifc_r.cry}, 8'd0);

    // Exhaustive sweep of all operand/carry-in combinations
    for (int i = 0; i < 16384; i++) begin
      logic [13:0] v;
      v = 14'(i);
      step(1'b1, 1'b1, v[7:0], v[13:8]);
    end

    // Random traffic with sporadic enable drops and resets
    for (int k = 0; k < 600; k++) begin
      step(($urandom_range(0, 15) != 0), 1'($urandom_range(0, 1)),
           8'($urandom), 6'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
